// File: rtl/pe_pkg.sv
// Shared types and packet layout helpers for the partial-sum packetizer.
// Optional parity MSB is enabled by defining PE_PKTZ_PARITY_EN.
package pe_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_SEND = 1'b1
  } pe_state_e;

  localparam int LANES  = 3;
  localparam int SEQ_W  = 2;
  localparam int LAST_W = 1;
  localparam int TS_W   = 1;
  localparam int DIR_W  = 1;

`ifdef PE_PKTZ_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  // Header starts directly above the three lanes.
  function automatic int hdr_off_f(input int fw);
    return LANES * fw;
  endfunction

  function automatic int hdr_w_f(input int hw);
    return DIR_W + 2 * hw + TS_W + LAST_W + SEQ_W;
  endfunction

  function automatic int pkt_w_f(input int fw, input int hw);
    return hdr_off_f(fw) + hdr_w_f(hw) + PAR_W;
  endfunction

endpackage

// File: rtl/pe_pkt_lane_buf.sv
// Three-lane fill register: words land in lane0, lane1, lane2 in order of arrival.
module pe_pkt_lane_buf
  import pe_pkg::*;
#(
  parameter int FILTER_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [FILTER_WIDTH-1:0] wr_data,
  input  logic                    wr_ts,
  input  logic                    clr,
  output logic [FILTER_WIDTH-1:0] lane0,
  output logic [FILTER_WIDTH-1:0] lane1,
  output logic [FILTER_WIDTH-1:0] lane2,
  output logic [1:0]              lane_cnt,
  output logic                    lane0_ts
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane0    <= '0;
      lane1    <= '0;
      lane2    <= '0;
      lane_cnt <= 2'd0;
      lane0_ts <= 1'b0;
    end else if (clr) begin
      // Clearing on transmit keeps unfilled lanes of the next packet at zero.
      lane0    <= '0;
      lane1    <= '0;
      lane2    <= '0;
      lane_cnt <= 2'd0;
      lane0_ts <= 1'b0;
    end else if (wr_en) begin
      case (lane_cnt)
        2'd0: begin
          lane0    <= wr_data;
          lane0_ts <= wr_ts;
        end
        2'd1:    lane1 <= wr_data;
        default: lane2 <= wr_data;
      endcase
      lane_cnt <= lane_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/pe_packetizer.sv
// Packs up to three partial-sum words into one routed packet with a fixed header.
// Defining PE_PKTZ_PARITY_EN adds an even-parity MSB over the rest of the packet.
module pe_packetizer
  import pe_pkg::*;
#(
  parameter int FILTER_WIDTH = 8,
  parameter int HOP_W        = 2,
  parameter int DIRECTION    = 0,
  parameter int X_HOP        = 0,
  parameter int Y_HOP        = 0
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [FILTER_WIDTH-1:0]                 in_data,
  input  logic                                    in_timestep,
  input  logic                                    in_last,
  output logic                                    pkt_valid,
  input  logic                                    pkt_ready,
  output logic [pkt_w_f(FILTER_WIDTH, HOP_W)-1:0] pkt_data,
  output logic                                    err
);

  localparam int PKT_W  = pkt_w_f(FILTER_WIDTH, HOP_W);
  localparam int BODY_W = hdr_off_f(FILTER_WIDTH) + hdr_w_f(HOP_W);

  pe_state_e state, state_nxt;

  logic                    rdy_en;
  logic [SEQ_W-1:0]        seq;
  logic                    last_hdr;
  logic                    accept;
  logic                    close;
  logic                    send;
  logic [FILTER_WIDTH-1:0] lane0, lane1, lane2;
  logic [1:0]              lane_cnt;
  logic                    lane0_ts;
  logic [BODY_W-1:0]       pkt_body;
  logic [PKT_W-1:0]        pkt_word;

  assign in_ready  = rdy_en && (state == ST_FILL);
  assign pkt_valid = (state == ST_SEND);
  assign accept    = in_valid && in_ready;
  assign close     = accept && (in_last || (lane_cnt == 2'd2));
  assign send      = pkt_valid && pkt_ready;

  pe_pkt_lane_buf #(
    .FILTER_WIDTH(FILTER_WIDTH)
  ) u_lane_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept),
    .wr_data (in_data),
    .wr_ts   (in_timestep),
    .clr     (send),
    .lane0   (lane0),
    .lane1   (lane1),
    .lane2   (lane2),
    .lane_cnt(lane_cnt),
    .lane0_ts(lane0_ts)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FILL: if (close)     state_nxt = ST_SEND;
      ST_SEND: if (pkt_ready) state_nxt = ST_FILL;
      default:                state_nxt = ST_FILL;
    endcase
  end

  // in_ready is held low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_hdr <= 1'b0;
      seq      <= '0;
      err      <= 1'b0;
    end else begin
      if (close) last_hdr <= in_last;
      if (send)  seq <= last_hdr ? '0 : seq + 1'b1;
      if (accept && (lane_cnt != 2'd0) && (in_timestep != lane0_ts)) err <= 1'b1;
    end
  end

  assign pkt_body = {DIR_W'(DIRECTION), HOP_W'(X_HOP), HOP_W'(Y_HOP),
                     lane0_ts, last_hdr, seq, lane2, lane1, lane0};

`ifdef PE_PKTZ_PARITY_EN
  function automatic logic even_par(input logic [BODY_W-1:0] v);
    return ^v;
  endfunction

  assign pkt_word = {even_par(pkt_body), pkt_body};
`else
  assign pkt_word = pkt_body;
`endif

  // Outside SEND the packet bus is driven to zero so reset and idle read as 0.
  assign pkt_data = (state == ST_SEND) ? pkt_word : '0;

endmodule

// File: tb/tb_pe_packetizer.sv
// Randomized and directed checks of pe_packetizer against a word-queue reference model.
module tb_pe_packetizer;
`ifdef PE_PKTZ_PARITY_EN
  localparam int PKT_W = 34;
`else
  localparam int PKT_W = 33;
`endif
  localparam int DIR = 1;
  localparam int XH  = 2;
  localparam int YH  = 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_data = 8'h00;
  logic             in_timestep = 1'b0;
  logic             in_last = 1'b0;
  logic             pkt_valid;
  logic             pkt_ready = 1'b0;
  logic [PKT_W-1:0] pkt_data;
  logic             err;

  int n_chk  = 0;
  int n_fail = 0;
  int n_pkts = 0;

  typedef struct {
    logic [7:0] d;
    logic       ts;
    logic       last;
  } word_t;

  word_t       cur[$];
  logic [63:0] exp_q[$];
  int          seq_m = 0;
  bit          exp_err = 1'b0;
  bit          stall = 1'b0;
  logic [63:0] stall_data = '0;

  pe_packetizer #(
    .FILTER_WIDTH(8),
    .HOP_W       (2),
    .DIRECTION   (DIR),
    .X_HOP       (XH),
    .Y_HOP       (YH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_timestep(in_timestep),
    .in_last    (in_last),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .pkt_data   (pkt_data),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_accept(input word_t w);
    logic [63:0] v;
    if (cur.size() > 0 && w.ts != cur[0].ts) exp_err = 1'b1;
    cur.push_back(w);
    if (cur.size() == 3 || w.last) begin
      v = '0;
      for (int i = 0; i < cur.size(); i++) v |= 64'(cur[i].d) << (8 * i);
      v |= 64'(seq_m) << 24;
      v |= 64'(w.last) << 26;
      v |= 64'(cur[0].ts) << 27;
      v |= 64'(YH) << 28;
      v |= 64'(XH) << 30;
      v |= 64'(DIR) << 32;
`ifdef PE_PKTZ_PARITY_EN
      v |= 64'(^v) << 33;
`endif
      exp_q.push_back(v);
      seq_m = w.last ? 0 : (seq_m + 1) % 4;
      cur.delete();
    end
  endtask

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur.delete();
      exp_q.delete();
      seq_m   = 0;
      exp_err = 1'b0;
      stall   = 1'b0;
    end else begin
      word_t w;
      if (pkt_valid && pkt_ready) begin
        if (exp_q.size() == 0) chk("unexpected_pkt", 64'(pkt_data), 64'hDEAD);
        else chk("pkt_data", 64'(pkt_data), exp_q.pop_front());
`ifdef PE_PKTZ_PARITY_EN
        chk("parity_xor", 64'(^pkt_data), 64'd0);
`endif
        n_pkts++;
      end
      if (stall) begin
        chk("stall_valid", 64'(pkt_valid), 64'd1);
        chk("stall_data", 64'(pkt_data), stall_data);
      end
      stall      = pkt_valid && !pkt_ready;
      stall_data = 64'(pkt_data);
      chk("ready_vs_valid", 64'(in_ready && pkt_valid), 64'd0);
      chk("err", 64'(err), 64'(exp_err));
      if (in_valid && in_ready) begin
        w.d = in_data; w.ts = in_timestep; w.last = in_last;
        model_accept(w);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_pkt_valid", 64'(pkt_valid), 64'd0);
    chk("rst_pkt_data", 64'(pkt_data), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk("rel_in_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("rel_in_ready_high", 64'(in_ready), 64'd1);
  endtask

  task automatic send_word(input logic [7:0] d, input logic ts, input logic last);
    int t = 0;
    in_valid = 1'b1; in_data = d; in_timestep = ts; in_last = last;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || pkt_valid) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int base;
    logic ts_r;
    do_reset();

    // Three words closed by last: single packet, valid right after third accept.
    pkt_ready = 1'b1;
    send_word(8'h11, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0);
    chk("t036_no_valid_early", 64'(pkt_valid), 64'd0);
    send_word(8'h33, 1'b0, 1'b1);
    chk("t036_valid_latency", 64'(pkt_valid), 64'd1);
    chk("t036_pkt", 64'(pkt_data[32:0]), 64'h1_9433_2211);
    wait_idle();

    // Five words with ts=1, last on the fifth.
    for (int i = 0; i < 5; i++) send_word(8'(8'h40 + i), 1'b1, i == 4);
    wait_idle();

    // Downstream stall for ten cycles: one transfer on release.
    pkt_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_word(8'(8'hA0 + i), 1'b0, 1'b0);
    base = n_pkts;
    repeat (10) begin
      @(posedge clk); #1;
      chk("t038_in_ready", 64'(in_ready), 64'd0);
    end
    pkt_ready = 1'b1;
    wait_idle();
    chk("t038_one_xfer", 64'(n_pkts - base), 64'd1);

    // Single-word last packets keep seq at 0; full packets walk seq 0..3.
    for (int i = 0; i < 14; i++) send_word(8'($urandom), 1'b0, 1'b1);
    for (int i = 0; i < 36; i++) send_word(8'($urandom), 1'b1, 1'b0);
    wait_idle();

    // Timestep change inside a packet sets a sticky error.
    do_reset();
    send_word(8'h01, 1'b0, 1'b0);
    send_word(8'h02, 1'b1, 1'b1);
    wait_idle();
    repeat (5) @(posedge clk);
    #1 chk("t040_err_sticky", 64'(err), 64'd1);
    do_reset();
    chk("t040_err_cleared", 64'(err), 64'd0);

    // Reset while a packet is pending drops it immediately.
    pkt_ready = 1'b0;
    send_word(8'h55, 1'b0, 1'b1);
    @(posedge clk); #3;
    chk("t041_pending", 64'(pkt_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t041_valid_drop", 64'(pkt_valid), 64'd0);
    chk("t041_data_drop", 64'(pkt_data), 64'd0);
    do_reset();

    // Randomized traffic with random backpressure.
    ts_r = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 11) == 0) ts_r = ~ts_r;
      in_valid    = ($urandom_range(0, 3) != 0);
      in_data     = 8'($urandom);
      in_timestep = ts_r;
      in_last     = ($urandom_range(0, 4) == 0);
      pkt_ready   = ($urandom_range(0, 9) < 7);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    pkt_ready = 1'b1;
    wait_idle();
    chk("rand_pkts_seen", 64'(n_pkts > 100), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pe_packetizer.md
PE_PACKETIZER -- requirements
Module: pe_packetizer

Interface
REQ-001 Parameter FILTER_WIDTH, default 8, width of one partial-sum lane.
REQ-002 Parameter HOP_W, default 2, width of each hop-count header field.
REQ-003 Parameter DIRECTION, default 0, 1-bit routing direction placed in every header.
REQ-004 Parameter X_HOP, default 0, X hop count placed in every header.
REQ-005 Parameter Y_HOP, default 0, Y hop count placed in every header.
REQ-006 Derived PKT_W = 3*FILTER_WIDTH + 2*HOP_W + 5 (default 33); +1 when parity is enabled.
REQ-007 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-008 Port clk, input, 1, rising-edge clock.
REQ-009 Port rst_n, input, 1, asynchronous active-low reset.
REQ-010 Port in_valid, input, 1, partial-sum word offered.
REQ-011 Port in_ready, output, 1, block accepts word.
REQ-012 Port in_data, input, FILTER_WIDTH, partial-sum value.
REQ-013 Port in_timestep, input, 1, timestep tag of in_data.
REQ-014 Port in_last, input, 1, final word of current timestep.
REQ-015 Port pkt_valid, output, 1, packet offered downstream.
REQ-016 Port pkt_ready, input, 1, downstream accepts packet.
REQ-017 Port pkt_data, output, PKT_W, packet {[parity], DIRECTION, X_HOP, Y_HOP, timestep, last, seq[1:0], lane2, lane1, lane0}, MSB first.
REQ-018 Port err, output, 1, sticky protocol-error flag.

Function
REQ-019 The FSM SHALL have exactly two states: FILL (in_ready=1, pkt_valid=0) and SEND (in_ready=0, pkt_valid=1).
REQ-020 A word SHALL be accepted only on a rising edge with in_valid && in_ready.
REQ-021 Accepted words SHALL fill lane0, then lane1, then lane2 (lane0 at LSBs).
REQ-022 Accepting the third lane, or any word with in_last=1, SHALL close the packet and enter SEND on the same edge, giving pkt_valid one cycle after the closing accept.
REQ-023 Unfilled lanes of a closed packet SHALL be zero.
REQ-024 The header timestep field SHALL equal in_timestep of the packet's lane0 word; the header last field SHALL equal in_last of the closing word.
REQ-025 seq SHALL start at 0, increment per transmitted packet, wrap 3->0, and return to 0 after a packet with last=1.
REQ-026 pkt_data and pkt_valid SHALL remain stable while pkt_valid && !pkt_ready.
REQ-027 pkt_valid && pkt_ready SHALL return the FSM to FILL with the lane count at 0 on that edge; no same-cycle input bypass (peak throughput 3 words per 4 cycles).
REQ-028 An accepted word whose in_timestep differs from the open packet's lane0 timestep SHALL set err; the word is still packed.
REQ-029 err SHALL stay 1 until reset.

Reset
REQ-030 rst_n low SHALL asynchronously force FILL, lane count 0, seq 0, lanes 0, err 0, pkt_valid 0, pkt_data 0.
REQ-031 in_ready SHALL be 0 while rst_n is low and 1 from the first edge after deassertion.
REQ-032 Reset during SEND SHALL discard the pending packet with no partial transfer.

Configuration
REQ-033 Macro PE_PKTZ_PARITY_EN defined: pkt_data gains an MSB equal to even parity (XOR) over all other bits; undefined: no parity bit, PKT_W as in REQ-006.

Structure
REQ-034 Package pe_pkg SHALL hold the FSM state enum, header field widths/offsets and the PKT_W derivation function.
REQ-035 One sub-module, pe_pkt_lane_buf (three-lane fill register with lane counter), SHALL be instantiated; the FSM and header logic reside in pe_packetizer.

Verification (defaults, DIRECTION=1, X_HOP=2, Y_HOP=1)
REQ-036 Words 0x11,0x22,0x33, ts=0, last on 0x33, pkt_ready=1 -> one packet, lanes 33/22/11, seq=0, last=1, pkt_valid one cycle after third accept.
REQ-037 Five words, last on fifth, ts=1 -> packets seq=0 (last=0, three lanes) then seq=1 (last=1, lane2=0).
REQ-038 pkt_ready low for 10 cycles -> pkt_data stable, in_ready=0 throughout, single transfer on release.
REQ-039 Fourteen consecutive single-word last=1 packets -> seq stays 0; twelve full packets without last -> seq 0,1,2,3,0,...
REQ-040 ts=0 word followed by ts=1 word in same packet -> err=1, persists until rst_n pulse.
REQ-041 rst_n asserted while pkt_valid=1 -> pkt_valid drops immediately; with PE_PKTZ_PARITY_EN, every packet's 34 bits XOR to 0.
